lfsr_way_sel: RTL and testbench



---
 rtl/lfsr_way_sel.sv | 115 +++++++++++
 tb/tb_lfsr_way_sel.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_way_sel.sv
// Pseudo-random replacement-way selector: maximal-length Fibonacci LFSR with
// rejection of out-of-range candidates, valid/ready handshake and reseeding.
module lfsr_way_sel #(
  parameter int                   LfsrWidth = 8,
  parameter logic [LfsrWidth-1:0] Seed      = '1,
  parameter int                   NumWays   = 8,
  parameter int                   LogWays   = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 seed_load_i,
  input  logic [LfsrWidth-1:0] seed_i,
  input  logic                 way_ready_i,
  output logic                 way_valid_o,
  output logic [LogWays-1:0]   way_bin_o,
  output logic [NumWays-1:0]   way_oh_o,
  output logic [LfsrWidth-1:0] state_o
);

  // Feedback tap masks (bit t-1 set for tap t) for each supported width.
  function automatic logic [15:0] tap_mask(input int width);
    case (width)
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0E08;
      13:      tap_mask = 16'h1C80;
      14:      tap_mask = 16'h3802;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  if (LfsrWidth < 4 || LfsrWidth > 16) begin : g_bad_width
    $fatal(1, "lfsr_way_sel: LfsrWidth %0d outside 4..16", LfsrWidth);
  end
  if (NumWays < 1 || NumWays > (1 << LfsrWidth)) begin : g_bad_ways
    $fatal(1, "lfsr_way_sel: NumWays %0d outside 1..2^LfsrWidth", NumWays);
  end

  localparam logic [15:0]          TapFull    = tap_mask(LfsrWidth);
  localparam logic [LfsrWidth-1:0] TapMask    = TapFull[LfsrWidth-1:0];
  localparam logic [LfsrWidth-1:0] One        = {{(LfsrWidth-1){1'b0}}, 1'b1};
  localparam logic [LfsrWidth-1:0] ResetState = (Seed == '0) ? One : Seed;
  localparam logic [LogWays:0]     NumWaysW   = (LogWays+1)'(NumWays);

  logic [LfsrWidth-1:0] q_r;
  logic [LfsrWidth-1:0] q_next_s;
  logic [LogWays-1:0]   cand_s;
  logic                 valid_s;
  logic                 fb_s;
  logic                 adv_s;

  if (NumWays == 1) begin : g_single
    assign cand_s  = '0;
    assign valid_s = 1'b1;
  end else begin : g_multi
    assign cand_s  = q_r[LogWays-1:0];
    assign valid_s = ({1'b0, cand_s} < NumWaysW);
  end

  assign fb_s  = ^(q_r & TapMask);
  // Out-of-range candidates are skipped without waiting for the consumer.
  assign adv_s = valid_s ? way_ready_i : 1'b1;

  // Next-state selection: seed load, lock-up recovery, advance, hold.
  always_comb begin
    q_next_s = q_r;
    if (seed_load_i) begin
      if (seed_i == '0) begin
        q_next_s = One;
      end else begin
        q_next_s = seed_i;
      end
    end else if (q_r == '0) begin
      q_next_s = One;
    end else if (adv_s) begin
      q_next_s = {q_r[LfsrWidth-2:0], fb_s};
    end else begin
      q_next_s = q_r;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_r <= ResetState;
    end else begin
      q_r <= q_next_s;
    end
  end

  // One-hot decode, suppressed while the candidate is rejected.
  always_comb begin
    way_oh_o = '0;
    for (int i = 0; i < NumWays; i++) begin
      if (valid_s && (cand_s == LogWays'(i))) begin
        way_oh_o[i] = 1'b1;
      end else begin
        way_oh_o[i] = 1'b0;
      end
    end
  end

  assign way_valid_o = valid_s;
  assign way_bin_o   = cand_s;
  assign state_o     = q_r;

endmodule

// File: tb/tb_lfsr_way_sel.sv
// Self-checking bench for lfsr_way_sel: vector table, corner sequences and
// randomized traffic against a behavioural model, on three configurations.
module tb_lfsr_way_sel;

  logic clk;
  logic rst;

  logic         load_a, load_b, load_c;
  logic [7:0]   seed_a, seed_b, seed_c;
  logic         ready_a, ready_b, ready_c;
  logic         valid_a, valid_b, valid_c;
  logic [7:0]   bin_a;
  logic [2:0]   bin_b;
  logic [0:0]   bin_c;
  logic [255:0] oh_a;
  logic [4:0]   oh_b;
  logic [0:0]   oh_c;
  logic [7:0]   state_a, state_b, state_c;

  int checks;
  int errors;

  lfsr_way_sel #(.LfsrWidth(8), .Seed(8'h01), .NumWays(256)) dut_a (
    .clk_i(clk), .rst_i(rst), .seed_load_i(load_a), .seed_i(seed_a),
    .way_ready_i(ready_a), .way_valid_o(valid_a), .way_bin_o(bin_a),
    .way_oh_o(oh_a), .state_o(state_a));

  lfsr_way_sel #(.LfsrWidth(8), .Seed(8'h07), .NumWays(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .seed_load_i(load_b), .seed_i(seed_b),
    .way_ready_i(ready_b), .way_valid_o(valid_b), .way_bin_o(bin_b),
    .way_oh_o(oh_b), .state_o(state_b));

  lfsr_way_sel #(.LfsrWidth(8), .NumWays(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .seed_load_i(load_c), .seed_i(seed_c),
    .way_ready_i(ready_c), .way_valid_o(valid_c), .way_bin_o(bin_c),
    .way_oh_o(oh_c), .state_o(state_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [7:0] seed;
    logic       ready;
    logic [7:0] exp_state;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Maximal-length 8-bit sequence from taps 8,6,5,4.
  function automatic logic [7:0] model_step(input logic [7:0] s);
    int   taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[k]) fb ^= s[taps[k]-1];
    return 8'((s << 1) | {7'd0, fb});
  endfunction

  function automatic int log_ways(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  function automatic int model_cand(input int nw, input logic [7:0] s);
    return (nw == 1) ? 0 : (int'(s) % (1 << log_ways(nw)));
  endfunction

  function automatic logic model_valid(input int nw, input logic [7:0] s);
    return model_cand(nw, s) < nw;
  endfunction

  function automatic logic [255:0] model_oh(input int nw, input logic [7:0] s);
    logic [255:0] v = '0;
    if (model_valid(nw, s)) v[model_cand(nw, s)] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_next(input int nw, input logic [7:0] s,
                                            input logic ld, input logic [7:0] sd,
                                            input logic rdy);
    if (ld) return (sd == 8'h00) ? 8'h01 : sd;
    if (s == 8'h00) return 8'h01;
    if (!model_valid(nw, s) || rdy) return model_step(s);
    return s;
  endfunction

  task automatic chk_b(input string tag, input logic [7:0] s);
    chk({tag, " state_b"}, 256'(state_b), 256'(s));
    chk({tag, " valid_b"}, 256'(valid_b), 256'(model_valid(5, s)));
    chk({tag, " bin_b"},   256'(bin_b),   256'(model_cand(5, s)));
    chk({tag, " oh_b"},    256'(oh_b),    model_oh(5, s));
  endtask

  task automatic idle_inputs();
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    seed_a = 8'h00; seed_b = 8'h00; seed_c = 8'h00;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
  endtask

  initial begin
    logic [7:0] ma, mb, mc;
    int         period;
    logic       saw_zero;

    checks = 0;
    errors = 0;
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h0E, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h1D, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h3A, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h3A, 1'b1};
    tbl[4]  = '{1'b1, 8'h55, 1'b1, 8'h55, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hAB, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'h01, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h08, 1'b1};

    idle_inputs();
    rst = 1'b1;
    #12;
    chk("reset state_a", 256'(state_a), 256'(8'h01));
    chk("reset state_c", 256'(state_c), 256'(8'hFF));
    chk("reset valid_c", 256'(valid_c), 256'(1'b1));
    chk("reset bin_c",   256'(bin_c),   256'(1'b0));
    chk_b("reset", 8'h07);
    rst = 1'b0;

    // Rejection, hold, seed-vs-handshake and zero-seed on the NumWays=5 instance.
    for (int i = 0; i < 11; i++) begin
      load_b  = tbl[i].load;
      seed_b  = tbl[i].seed;
      ready_b = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d] valid_b", i), 256'(valid_b), 256'(tbl[i].exp_valid));
      chk_b($sformatf("tbl[%0d]", i), tbl[i].exp_state);
    end
    idle_inputs();

    // Full period of the 256-way instance with the consumer always ready.
    ready_a  = 1'b1;
    period   = 0;
    saw_zero = 1'b0;
    ma       = 8'h01;
    do begin
      @(posedge clk);
      #1;
      period++;
      ma = model_step(ma);
      if (state_a == 8'h00) saw_zero = 1'b1;
      if (period <= 4) chk($sformatf("seq[%0d] state_a", period), 256'(state_a), 256'(ma));
    end while (state_a != 8'h01 && period < 300);
    chk("period state_a", 256'(period), 256'(255));
    chk("no zero state_a", 256'(saw_zero), 256'(1'b0));

    // Feedback wrap from the top bit.
    load_a = 1'b1;
    seed_a = 8'h80;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap state_a", 256'(state_a), 256'(8'h01));
    idle_inputs();

    // Asynchronous reset in the middle of a rejection run.
    load_b = 1'b1;
    seed_b = 8'hFF;
    @(posedge clk);
    #1;
    idle_inputs();
    chk_b("pre-rst", 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk_b("async rst", 8'h07);
    chk("async rst state_a", 256'(state_a), 256'(8'h01));
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the behavioural model.
    ma = 8'h01;
    mb = 8'h07;
    mc = 8'hFF;
    for (int n = 0; n < 600; n++) begin
      load_a  = ($urandom_range(7) == 0);
      load_b  = ($urandom_range(7) == 0);
      load_c  = ($urandom_range(7) == 0);
      seed_a  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      seed_b  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      seed_c  = 8'($urandom);
      ready_a = 1'($urandom);
      ready_b = 1'($urandom);
      ready_c = 1'($urandom);
      ma = model_next(256, ma, load_a, seed_a, ready_a);
      mb = model_next(5,   mb, load_b, seed_b, ready_b);
      mc = model_next(1,   mc, load_c, seed_c, ready_c);
      @(posedge clk);
      #1;
      chk("rnd state_a", 256'(state_a), 256'(ma));
      chk("rnd valid_a", 256'(valid_a), 256'(model_valid(256, ma)));
      chk("rnd bin_a",   256'(bin_a),   256'(model_cand(256, ma)));
      chk("rnd oh_a",    oh_a,          model_oh(256, ma));
      chk_b("rnd", mb);
      chk("rnd state_c", 256'(state_c), 256'(mc));
      chk("rnd valid_c", 256'(valid_c), 256'(model_valid(1, mc)));
      chk("rnd bin_c",   256'(bin_c),   256'(model_cand(1, mc)));
      chk("rnd oh_c",    256'(oh_c),    model_oh(1, mc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
